// File: rtl/ppu_ctrl_pkg.sv
// Control-bundle definitions shared by Control_Unit, the control pipeline and
// the stage consumers that pick individual enables out of a registered bundle.
package ppu_ctrl_pkg;

  localparam int CTRL_BUNDLE_W = 27;

  typedef struct packed {
    logic       load;
    logic       rf_en;
    logic       ram_en;
    logic       rw;
    logic       se;
    logic       jalr;
    logic       jal;
    logic       auipc;
    logic [2:0] shift_imm;
    logic [3:0] alu_op;
    logic [1:0] ram_size;
    logic [9:0] comb_opfunct;
  } ctrl_bundle_t;

  // Bit offsets / widths of each field inside the packed bundle
  localparam int OFF_COMB_OPFUNCT = 0;   localparam int W_COMB_OPFUNCT = 10;
  localparam int OFF_RAM_SIZE     = 10;  localparam int W_RAM_SIZE     = 2;
  localparam int OFF_ALU_OP       = 12;  localparam int W_ALU_OP       = 4;
  localparam int OFF_SHIFT_IMM    = 16;  localparam int W_SHIFT_IMM    = 3;
  localparam int OFF_AUIPC        = 19;
  localparam int OFF_JAL          = 20;
  localparam int OFF_JALR         = 21;
  localparam int OFF_SE           = 22;
  localparam int OFF_RW           = 23;
  localparam int OFF_RAM_EN       = 24;
  localparam int OFF_RF_EN        = 25;
  localparam int OFF_LOAD         = 26;

  // NOP must be all-zero so a bubble can never assert an enable downstream
  localparam logic [CTRL_BUNDLE_W-1:0] NOP_CTRL = '0;

  function automatic logic [CTRL_BUNDLE_W-1:0] pack_ctrl(input ctrl_bundle_t b);
    return b;
  endfunction

  function automatic ctrl_bundle_t unpack_ctrl(input logic [CTRL_BUNDLE_W-1:0] v);
    return ctrl_bundle_t'(v);
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One control-pipeline register: bundle plus valid bit, with flush > hold >
// bubble > load priority under a synchronous reset.
module ctrl_pipe_stage #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         flush_i,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  logic [W-1:0] src_ctrl_i,
  input  logic         src_valid_i,
  output logic [W-1:0] ctrl_o,
  output logic         valid_o
);

  logic [W:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (flush_i)       stage_d = '0;
    else if (hold_i)   stage_d = stage_q;
    else if (bubble_i) stage_d = '0;
    // an invalid entry is stored as NOP so its enables stay low
    else               stage_d = src_valid_i ? {1'b1, src_ctrl_i} : '0;
  end

  always_ff @(posedge clk) begin
    if (Reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign valid_o = stage_q[W];
  assign ctrl_o  = stage_q[W-1:0];

endmodule

// File: rtl/ctrl_signal_pipeline.sv
// Parametrised ID/EX..MEM/WB control-bundle pipeline with per-stage hold/flush,
// bubble insertion behind holds, upstream stall and saturating retire/stall counters.
module ctrl_signal_pipeline
  import ppu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 27,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic [CTRL_W-1:0]            id_ctrl_in,
  input  logic                         id_valid_in,
  input  logic                         nop_sel,
  input  logic [STAGES-1:0]            hold_mask,
  input  logic [STAGES-1:0]            flush_mask,
  output logic [STAGES*CTRL_W-1:0]     stage_ctrl,
  output logic [STAGES-1:0]            stage_valid,
  output logic                         upstream_le,
  output logic [$clog2(STAGES+1)-1:0]  occupancy,
  output logic [CNT_W-1:0]             retire_count,
  output logic [CNT_W-1:0]             stall_count
);

  localparam int OCC_W = $clog2(STAGES+1);
  localparam logic [CTRL_W-1:0] NOP = CTRL_W'(NOP_CTRL);

  logic [STAGES-1:0]             eff_hold, bubble;
  logic [STAGES-1:0][CTRL_W-1:0] ctrl_q, src_ctrl;
  logic [STAGES-1:0]             valid_q, src_valid;
  logic [CNT_W-1:0]              retire_q, retire_d, stall_q, stall_d;
  logic                          retire_now;

  // A hold anywhere freezes every stage upstream of it
  always_comb begin
    eff_hold = '0;
    for (int k = 0; k < STAGES; k++) eff_hold[k] = |(hold_mask >> k);
  end

  always_comb begin
    src_ctrl     = '0;
    src_valid    = '0;
    bubble       = '0;
    src_ctrl[0]  = nop_sel ? NOP : id_ctrl_in;
    src_valid[0] = ~nop_sel & id_valid_in;
    for (int k = 1; k < STAGES; k++) begin
      src_ctrl[k]  = ctrl_q[k-1];
      src_valid[k] = valid_q[k-1];
      bubble[k]    = eff_hold[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    ctrl_pipe_stage #(.W(CTRL_W)) u_stage (
      .clk        (clk),
      .Reset      (Reset),
      .flush_i    (flush_mask[k]),
      .hold_i     (eff_hold[k]),
      .bubble_i   (bubble[k]),
      .src_ctrl_i (src_ctrl[k]),
      .src_valid_i(src_valid[k]),
      .ctrl_o     (ctrl_q[k]),
      .valid_o    (valid_q[k])
    );
  end

  assign upstream_le = ~eff_hold[0];
  assign retire_now  = valid_q[STAGES-1] & ~eff_hold[STAGES-1] & ~flush_mask[STAGES-1];

  always_comb begin
    retire_d = retire_q;
    stall_d  = stall_q;
    if (retire_now && retire_q != '1) retire_d = retire_q + CNT_W'(1);
    if (!upstream_le && stall_q != '1) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      retire_q <= retire_d;
      stall_q  <= stall_d;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) occupancy = occupancy + OCC_W'(valid_q[k]);
  end

  assign stage_ctrl   = ctrl_q;
  assign stage_valid  = valid_q;
  assign retire_count = retire_q;
  assign stall_count  = stall_q;

endmodule

// File: tb/tb_ctrl_signal_pipeline.sv
// Randomised and scenario stimulus for ctrl_signal_pipeline, checked every cycle
// against a per-stage array model built from the pipeline's update rules.
module tb_ctrl_signal_pipeline;

  localparam int W  = 27;
  localparam int S  = 3;
  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk;
  logic            Reset;
  logic [W-1:0]    id_ctrl_in;
  logic            id_valid_in;
  logic            nop_sel;
  logic [S-1:0]    hold_mask, flush_mask;
  logic [S*W-1:0]  stage_ctrl;
  logic [S-1:0]    stage_valid;
  logic            upstream_le;
  logic [1:0]      occupancy;
  logic [CW-1:0]   retire_count, stall_count;

  ctrl_signal_pipeline #(.CTRL_W(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .id_ctrl_in  (id_ctrl_in),
    .id_valid_in (id_valid_in),
    .nop_sel     (nop_sel),
    .hold_mask   (hold_mask),
    .flush_mask  (flush_mask),
    .stage_ctrl  (stage_ctrl),
    .stage_valid (stage_valid),
    .upstream_le (upstream_le),
    .occupancy   (occupancy),
    .retire_count(retire_count),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: contents of each stage as seen after the last edge
  logic [W-1:0] m_ctrl [S];
  bit           m_val  [S];
  int           m_ret, m_stl;

  function automatic bit held(input int k, input logic [S-1:0] h);
    return (h >> k) != 0;
  endfunction

  task automatic model_edge(input bit rst, input logic [W-1:0] c, input bit v,
                            input bit ns, input logic [S-1:0] h, input logic [S-1:0] f);
    logic [W-1:0] nc [S];
    bit           nv [S];
    if (rst) begin
      for (int k = 0; k < S; k++) begin m_ctrl[k] = '0; m_val[k] = 0; end
      m_ret = 0; m_stl = 0;
      return;
    end
    if (m_val[S-1] && !held(S-1, h) && !f[S-1]) m_ret = (m_ret < CMAX) ? m_ret + 1 : CMAX;
    if (held(0, h)) m_stl = (m_stl < CMAX) ? m_stl + 1 : CMAX;
    for (int k = 0; k < S; k++) begin
      logic [W-1:0] sc; bit sv;
      if (k == 0) begin sv = v && !ns; sc = sv ? c : '0; end
      else        begin sv = m_val[k-1]; sc = m_ctrl[k-1]; end
      if (f[k])                        begin nc[k] = '0; nv[k] = 0; end
      else if (held(k, h))             begin nc[k] = m_ctrl[k]; nv[k] = m_val[k]; end
      else if (k > 0 && held(k-1, h))  begin nc[k] = '0; nv[k] = 0; end
      else                             begin nc[k] = sc; nv[k] = sv; end
    end
    for (int k = 0; k < S; k++) begin m_ctrl[k] = nc[k]; m_val[k] = nv[k]; end
  endtask

  task automatic check_outputs();
    logic [S*W-1:0] ec;
    logic [S-1:0]   ev;
    int             occ;
    occ = 0;
    for (int k = 0; k < S; k++) begin
      ec[k*W +: W] = m_ctrl[k];
      ev[k]        = m_val[k];
      occ += m_val[k] ? 1 : 0;
    end
    chk("stage_ctrl",   stage_ctrl,   ec);
    chk("stage_valid",  stage_valid,  ev);
    chk("occupancy",    occupancy,    occ);
    chk("retire_count", retire_count, m_ret);
    chk("stall_count",  stall_count,  m_stl);
  endtask

  // Apply one cycle of inputs (from a negedge), check the combinational stall,
  // let the edge happen, then check all registered outputs on the next negedge.
  task automatic step(input bit rst, input logic [W-1:0] c, input bit v, input bit ns,
                      input logic [S-1:0] h, input logic [S-1:0] f);
    Reset = rst; id_ctrl_in = c; id_valid_in = v; nop_sel = ns;
    hold_mask = h; flush_mask = f;
    #1;
    chk("upstream_le", upstream_le, !held(0, h));
    @(posedge clk);
    model_edge(rst, c, v, ns, h, f);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic step_rand(input logic [S-1:0] h_force, input bit allow_rst);
    logic [S-1:0] h, f;
    for (int k = 0; k < S; k++) begin
      h[k] = ($urandom_range(0, 4) == 0);
      f[k] = ($urandom_range(0, 9) == 0);
    end
    step(allow_rst && ($urandom_range(0, 49) == 0), W'($urandom()),
         $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0, h | h_force, f);
  endtask

  localparam logic [W-1:0] A = 27'h5A5A5A5;
  localparam logic [W-1:0] B = 27'h3C3C3C3;
  localparam logic [W-1:0] C = 27'h7FFFFFF;
  localparam logic [W-1:0] D = 27'h1234567;

  initial begin
    int ret_snap;
    for (int k = 0; k < S; k++) begin m_ctrl[k] = '0; m_val[k] = 0; end
    m_ret = 0; m_stl = 0;

    // reset, then stream A..D
    step(1, '0, 0, 0, '0, '0);
    step(1, '0, 0, 0, '0, '0);
    chk("rst_occ", occupancy, 0);
    step(0, A, 1, 0, '0, '0);
    step(0, B, 1, 0, '0, '0);
    step(0, C, 1, 0, '0, '0);
    chk("lat_A_stage2", stage_ctrl[2*W +: W], A);
    step(0, D, 1, 0, '0, '0);
    chk("lat_B_stage2", stage_ctrl[2*W +: W], B);
    chk("steady_occ", occupancy, 3);
    step(0, A, 1, 0, '0, '0);
    chk("retire_two", retire_count, 2);

    // NOP bubble walks through
    step(0, B, 1, 1, '0, '0);
    step(0, C, 1, 0, '0, '0);
    step(0, D, 1, 0, '0, '0);
    step(0, A, 1, 0, '0, '0);

    // hold stage 1 for two cycles
    step(0, B, 1, 0, 3'b010, '0);
    step(0, B, 1, 0, 3'b010, '0);
    chk("hold_stall2", stall_count, 2);
    step(0, B, 1, 0, '0, '0);

    // hold and flush stage 1 together
    step(0, C, 1, 0, 3'b010, 3'b010);
    chk("hf_s1_invalid", stage_valid[1], 1'b0);
    step(0, C, 1, 0, '0, '0);
    step(0, D, 1, 0, '0, '0);
    step(0, A, 1, 0, '0, '0);

    // reset with full pipeline
    step(1, B, 1, 0, '0, '0);
    chk("rst_mid_valid", stage_valid, 3'b000);
    step(0, C, 1, 0, '0, '0);

    for (int i = 0; i < 3000; i++) step_rand('0, 1);

    // saturate the stall counter with the last stage held
    ret_snap = m_ret;
    for (int i = 0; i < 70000; i++) step_rand(3'b100, 0);
    chk("stall_sat", stall_count, 16'hFFFF);
    chk("retire_frozen", retire_count, ret_snap);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
